// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types and helpers for the trace capture controller.
//   trace_state_e : controller state encoding (exported on the state port)
//   trig_mode_e   : trigger condition select
//   is_halt_instr : true for the ECALL / EBREAK encodings that may end a window
package trace_capture_ctrl_pkg;

    typedef enum logic [1:0] {TS_IDLE, TS_ARMED, TS_CAPTURE, TS_DONE} trace_state_e;
    typedef enum logic [1:0] {TRIG_IMM, TRIG_PC, TRIG_CYCLE, TRIG_PC_CYCLE} trig_mode_e;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Retirement bus between the core and the trace capture controller, plus the
// logger-facing results.
//   cpu_valid, pc, instruction, cycle_count : core -> controller
//   log_enable  : controller -> logger enable (combinational)
//   trace_index : controller -> records emitted since trigger
interface trace_capture_ctrl_if;
    logic        cpu_valid;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] cycle_count;
    logic        log_enable;
    logic [31:0] trace_index;

    modport master (
        output cpu_valid, pc, instruction, cycle_count,
        input  log_enable, trace_index
    );

    modport slave (
        input  cpu_valid, pc, instruction, cycle_count,
        output log_enable, trace_index
    );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: arms on request, waits for a trigger, then enables
// the trace logger for a bounded, optionally decimated window of retired cycles.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   arm, abort          control pulses (abort wins)
//   trig_mode/pc/cycle  trigger configuration (latched on arm)
//   capture_len, decim  window length (0 = unlimited), log2 record stride
//   stop_on_halt        end window on ECALL / EBREAK
//   cpu                 retirement bus + log_enable / trace_index
//   state, triggered, done, halt_seen  registered status
//
// state      | meaning
// TS_IDLE    | inactive, waiting for arm
// TS_ARMED   | config latched, waiting for trigger hit
// TS_CAPTURE | window open, logging decimated valid cycles
// TS_DONE    | window ended (length or halt), waiting for re-arm
module trace_capture_ctrl
    import trace_capture_ctrl_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int DECIM_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [1:0]         trig_mode,
    input  logic [31:0]        trig_pc,
    input  logic [31:0]        trig_cycle,
    input  logic [LEN_W-1:0]   capture_len,
    input  logic [DECIM_W-1:0] decim,
    input  logic               stop_on_halt,
    trace_capture_ctrl_if.slave cpu,
    output trace_state_e       state,
    output logic               triggered,
    output logic               done,
    output logic               halt_seen
);

    // Largest stride is 2**(2**DECIM_W-1), so the counter needs that many bits.
    localparam int CNT_W = (1 << DECIM_W) - 1;

    trace_state_e       state_q, state_d;
    trig_mode_e         mode_q, mode_d;
    logic [31:0]        trig_pc_q, trig_pc_d;
    logic [31:0]        trig_cycle_q, trig_cycle_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic               soh_q, soh_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic [31:0]        index_q, index_d;
    logic               triggered_q, triggered_d;
    logic               done_q, done_d;
    logic               halt_seen_q, halt_seen_d;

    logic               log_en;
    logic               trig_cond;
    logic               halt_now;
    logic               emit;
    logic               len_hit;
    logic [CNT_W-1:0]   mask;
    logic [31:0]        index_inc;
    logic [31:0]        index_sat;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        trig_pc_d    = trig_pc_q;
        trig_cycle_d = trig_cycle_q;
        len_d        = len_q;
        decim_d      = decim_q;
        soh_d        = soh_q;
        dcnt_d       = dcnt_q;
        index_d      = index_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        halt_seen_d  = halt_seen_q;
        log_en       = 1'b0;

        mask = ~({CNT_W{1'b1}} << decim_q);

        unique case (mode_q)
            TRIG_IMM:      trig_cond = 1'b1;
            TRIG_PC:       trig_cond = (cpu.pc == trig_pc_q);
            TRIG_CYCLE:    trig_cond = (cpu.cycle_count >= trig_cycle_q);
            TRIG_PC_CYCLE: trig_cond = (cpu.pc == trig_pc_q) && (cpu.cycle_count >= trig_cycle_q);
            default:       trig_cond = 1'b0;
        endcase

        halt_now  = soh_q && cpu.cpu_valid && is_halt_instr(cpu.instruction);
        emit      = cpu.cpu_valid && (dcnt_q == '0);
        index_inc = index_q + 32'd1;
        index_sat = (&index_q) ? index_q : index_inc;
        // Window length counts the record being emitted now.
        len_hit   = (len_q != '0) && (index_inc == 32'(len_q));

        if (abort) begin
            state_d = TS_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                TS_IDLE, TS_DONE: begin
                    if (arm) begin
                        state_d      = TS_ARMED;
                        mode_d       = trig_mode_e'(trig_mode);
                        trig_pc_d    = trig_pc;
                        trig_cycle_d = trig_cycle;
                        len_d        = capture_len;
                        decim_d      = decim;
                        soh_d        = stop_on_halt;
                        dcnt_d       = '0;
                        index_d      = '0;
                        triggered_d  = 1'b0;
                        done_d       = 1'b0;
                        halt_seen_d  = 1'b0;
                    end
                end
                TS_ARMED: begin
                    if (cpu.cpu_valid && trig_cond) begin
                        log_en      = 1'b1;
                        triggered_d = 1'b1;
                        index_d     = 32'd1;
                        dcnt_d      = CNT_W'(1) & mask;
                        if (len_hit || halt_now) begin
                            state_d     = TS_DONE;
                            done_d      = 1'b1;
                            halt_seen_d = halt_now;
                        end else begin
                            state_d = TS_CAPTURE;
                        end
                    end
                end
                TS_CAPTURE: begin
                    if (cpu.cpu_valid) begin
                        dcnt_d = (dcnt_q + CNT_W'(1)) & mask;
                        // A halt is logged even on a decimated-out cycle.
                        if (emit || halt_now) begin
                            log_en  = 1'b1;
                            index_d = index_sat;
                            if (len_hit || halt_now) begin
                                state_d     = TS_DONE;
                                done_d      = 1'b1;
                                halt_seen_d = halt_now;
                            end
                        end
                    end
                end
                default: state_d = TS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TS_IDLE;
            mode_q       <= TRIG_IMM;
            trig_pc_q    <= '0;
            trig_cycle_q <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            soh_q        <= 1'b0;
            dcnt_q       <= '0;
            index_q      <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            halt_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            trig_pc_q    <= trig_pc_d;
            trig_cycle_q <= trig_cycle_d;
            len_q        <= len_d;
            decim_q      <= decim_d;
            soh_q        <= soh_d;
            dcnt_q       <= dcnt_d;
            index_q      <= index_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            halt_seen_q  <= halt_seen_d;
        end
    end

    assign cpu.log_enable  = log_en;
    assign cpu.trace_index = index_q;
    assign state           = state_q;
    assign triggered       = triggered_q;
    assign done            = done_q;
    assign halt_seen       = halt_seen_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: immediate, PC and cycle triggers,
// decimation with bubbles, halt termination, abort and async reset.
module tb_trace_capture_ctrl;
    import trace_capture_ctrl_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, abort;
    logic [1:0]  trig_mode;
    logic [31:0] trig_pc, trig_cycle;
    logic [15:0] capture_len;
    logic [3:0]  decim;
    logic        stop_on_halt;
    trace_state_e state;
    logic        triggered, done, halt_seen;

    trace_capture_ctrl_if u_if ();

    trace_capture_ctrl #(.LEN_W(16), .DECIM_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_pc      (trig_pc),
        .trig_cycle   (trig_cycle),
        .capture_len  (capture_len),
        .decim        (decim),
        .stop_on_halt (stop_on_halt),
        .cpu          (u_if),
        .state        (state),
        .triggered    (triggered),
        .done         (done),
        .halt_seen    (halt_seen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic        le_s;
    logic [31:0] idx_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; samples mid-cycle, returns at next posedge+1.
    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                         input logic [31:0] cc);
        u_if.cpu_valid   = v;
        u_if.pc          = p;
        u_if.instruction = ins;
        u_if.cycle_count = cc;
        @(negedge clk);
        le_s  = u_if.log_enable;
        idx_s = u_if.trace_index;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [31:0] p, input logic [31:0] c,
                          input logic [15:0] l, input logic [3:0] d, input logic s);
        trig_mode    = m;
        trig_pc      = p;
        trig_cycle   = c;
        capture_len  = l;
        decim        = d;
        stop_on_halt = s;
        arm          = 1'b1;
        drive(1'b0, 32'hFFFF_FFF0, NOP, 32'd0);
        arm = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_mode = 2'd0; trig_pc = '0; trig_cycle = '0;
        capture_len = '0; decim = '0; stop_on_halt = 1'b0;
        u_if.cpu_valid = 1'b0; u_if.pc = '0; u_if.instruction = NOP; u_if.cycle_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'(TS_IDLE));
        check("rst_index", u_if.trace_index, 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_halt", 32'(halt_seen), 32'd0);
        check("rst_le", 32'(u_if.log_enable), 32'd0);
        rst_n = 1'b1;
        #1;

        drive(1'b1, 32'd0, NOP, 32'd0);
        check("idle_le", 32'(le_s), 32'd0);

        // 1: immediate, len 4; later config changes must be ignored
        do_arm(2'd0, 32'd0, 32'd0, 16'd4, 4'd0, 1'b0);
        check("t1_armed", 32'(state), 32'(TS_ARMED));
        capture_len = 16'd9;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(i * 4), NOP, 32'(i));
            check($sformatf("t1_le%0d", i), 32'(le_s), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("t1_idx%0d", i), idx_s, (i < 4) ? 32'(i) : 32'd4);
        end
        check("t1_state", 32'(state), 32'(TS_DONE));
        check("t1_done", 32'(done), 32'd1);
        check("t1_trig", 32'(triggered), 32'd1);

        // 2: PC trigger at 0x10, len 3 (re-arm from DONE)
        do_arm(2'd1, 32'h10, 32'd0, 16'd3, 4'd0, 1'b0);
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_trig_clr", 32'(triggered), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(i * 4), NOP, 32'(i));
            check($sformatf("t2_le_pc%0h", i * 4), 32'(le_s),
                  (i >= 4 && i <= 6) ? 32'd1 : 32'd0);
        end
        check("t2_trig", 32'(triggered), 32'd1);
        check("t2_idx", u_if.trace_index, 32'd3);
        check("t2_state", 32'(state), 32'(TS_DONE));

        // 3: decim=2, len 3, bubbles after some valid cycles
        do_arm(2'd0, 32'd0, 32'd0, 16'd3, 4'd2, 1'b0);
        for (int v = 0; v < 12; v++) begin
            drive(1'b1, 32'(v * 4), NOP, 32'(v));
            check($sformatf("t3_le_v%0d", v), 32'(le_s),
                  (v == 0 || v == 4 || v == 8) ? 32'd1 : 32'd0);
            if (v % 3 == 1) begin
                drive(1'b0, 32'(v * 4), NOP, 32'(v));
                check($sformatf("t3_bub%0d", v), 32'(le_s), 32'd0);
            end
        end
        check("t3_idx", u_if.trace_index, 32'd3);
        check("t3_done", 32'(done), 32'd1);

        // 4: EBREAK on the 6th record, decim=1, unlimited length
        do_arm(2'd0, 32'd0, 32'd0, 16'd0, 4'd1, 1'b1);
        for (int j = 0; j < 13; j++) begin
            drive(1'b1, 32'(j * 4), (j == 10) ? INSTR_EBREAK : NOP, 32'(j));
            check($sformatf("t4_le%0d", j), 32'(le_s),
                  (j <= 10 && j % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t4_halt", 32'(halt_seen), 32'd1);
        check("t4_idx", u_if.trace_index, 32'd6);
        check("t4_state", 32'(state), 32'(TS_DONE));

        // 5: cycle trigger at 100, abort at 103
        do_arm(2'd2, 32'd0, 32'd100, 16'd0, 4'd0, 1'b0);
        for (int cc = 97; cc <= 103; cc++) begin
            abort = (cc == 103);
            drive(1'b1, 32'(cc * 4), NOP, 32'(cc));
            check($sformatf("t5_le_cc%0d", cc), 32'(le_s),
                  (cc >= 100 && cc <= 102) ? 32'd1 : 32'd0);
        end
        abort = 1'b0;
        check("t5_state", 32'(state), 32'(TS_IDLE));
        check("t5_done", 32'(done), 32'd0);
        arm = 1'b1; abort = 1'b1;
        drive(1'b0, 32'd0, NOP, 32'd0);
        arm = 1'b0; abort = 1'b0;
        check("t5_arm_abort", 32'(state), 32'(TS_IDLE));

        // 6: async reset in CAPTURE, then re-arm
        do_arm(2'd0, 32'd0, 32'd0, 16'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(i * 4), NOP, 32'(i));
        check("t6_cap", 32'(state), 32'(TS_CAPTURE));
        u_if.cpu_valid = 1'b1;
        #2;
        check("t6_le_pre", 32'(u_if.log_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(state), 32'(TS_IDLE));
        check("t6_rst_le", 32'(u_if.log_enable), 32'd0);
        check("t6_rst_idx", u_if.trace_index, 32'd0);
        check("t6_rst_trig", 32'(triggered), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_arm(2'd0, 32'd0, 32'd0, 16'd2, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), NOP, 32'(i));
            check($sformatf("t6_le%0d", i), 32'(le_s), (i < 2) ? 32'd1 : 32'd0);
        end
        check("t6_done", 32'(done), 32'd1);
        check("t6_idx", u_if.trace_index, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
